// File: rtl/cla_ctrl_pkg.sv
// Shared types and helpers for the word-serial carry-lookahead add controller.
package cla_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cla_state_e;

    // Word counter width; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage

// File: rtl/cla_multiword_ctrl_if.sv
// Request/result bundle between a wide-arithmetic user and cla_multiword_ctrl.
// The sub_i signal exists only when CLA_SUB_EN is defined.
interface cla_multiword_ctrl_if #(
    parameter int unsigned W     = 16,
    parameter int unsigned WORDS = 4
);
    logic                 start_i;
    logic [WORDS*W-1:0]   A_i;
    logic [WORDS*W-1:0]   B_i;
    logic                 P_i;
`ifdef CLA_SUB_EN
    logic                 sub_i;
`endif
    logic                 busy_o;
    logic                 done_o;
    logic [WORDS*W-1:0]   S_o;
    logic                 C_o;

`ifdef CLA_SUB_EN
    modport master (output start_i, A_i, B_i, P_i, sub_i,
                    input  busy_o, done_o, S_o, C_o);
    modport slave  (input  start_i, A_i, B_i, P_i, sub_i,
                    output busy_o, done_o, S_o, C_o);
`else
    modport master (output start_i, A_i, B_i, P_i,
                    input  busy_o, done_o, S_o, C_o);
    modport slave  (input  start_i, A_i, B_i, P_i,
                    output busy_o, done_o, S_o, C_o);
`endif

endinterface

// File: rtl/cla_word_slice.sv
// Combinational W-bit carry-lookahead adder built as a Kogge-Stone prefix over
// (generate, propagate) pairs, with the carry-in folded in as position 0.
module cla_word_slice #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0] A_i,
    input  logic [W-1:0] B_i,
    input  logic         P_i,
    output logic [W-1:0] S_o,
    output logic         C_o
);

    always_comb begin
        logic [W:0] gg;
        logic [W:0] pp;
        gg      = {A_i & B_i, P_i};
        pp      = {A_i ^ B_i, 1'b0};
        // Descending i keeps gg[i-d] at the previous prefix level.
        for (int d = 1; d <= int'(W); d = d * 2) begin
            for (int i = int'(W); i >= d; i--) begin
                gg[i] = gg[i] | (pp[i] & gg[i-d]);
                pp[i] = pp[i] & pp[i-d];
            end
        end
        S_o = (A_i ^ B_i) ^ gg[W-1:0];
        C_o = gg[W];
    end

endmodule

// File: rtl/cla_multiword_ctrl.sv
// Word-serial WORDS*W-bit adder sequencing one shared cla_word_slice, LSW first.
// Optional A-B mode is enabled by defining CLA_SUB_EN.
module cla_multiword_ctrl
    import cla_ctrl_pkg::*;
#(
    parameter int unsigned W     = 16,
    parameter int unsigned WORDS = 4
) (
    input  logic                  CLK_i,
    input  logic                  rst_n_i,
    cla_multiword_ctrl_if.slave   bus
);

    localparam int unsigned   KW     = cnt_width(WORDS);
    localparam logic [KW-1:0] K_LAST = KW'(WORDS - 1);

    cla_state_e           state_q, state_d;
    logic [KW-1:0]        k_q;
    logic [WORDS*W-1:0]   a_q, b_q, s_q;
    logic                 carry_q, c_q;
`ifdef CLA_SUB_EN
    logic                 sub_q;
`endif

    logic [W-1:0] a_word, b_word, sum_word;
    logic         c_word;
    logic         accept, last;

    assign accept = (state_q == IDLE) && bus.start_i;
    assign last   = (state_q == RUN) && (k_q == K_LAST);

    always_comb begin
        a_word = a_q[k_q*W +: W];
`ifdef CLA_SUB_EN
        b_word = b_q[k_q*W +: W] ^ {W{sub_q}};
`else
        b_word = b_q[k_q*W +: W];
`endif
    end

    cla_word_slice #(
        .W (W)
    ) u_slice (
        .A_i (a_word),
        .B_i (b_word),
        .P_i (carry_q),
        .S_o (sum_word),
        .C_o (c_word)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start_i) state_d = RUN;
            RUN:     if (k_q == K_LAST) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            k_q     <= '0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            carry_q <= 1'b0;
            c_q     <= 1'b0;
`ifdef CLA_SUB_EN
            sub_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                a_q     <= bus.A_i;
                b_q     <= bus.B_i;
                k_q     <= '0;
                s_q     <= '0;
                c_q     <= 1'b0;
`ifdef CLA_SUB_EN
                sub_q   <= bus.sub_i;
                // Two's-complement subtract: invert B and inject +1.
                carry_q <= bus.sub_i ? 1'b1 : bus.P_i;
`else
                carry_q <= bus.P_i;
`endif
            end else if (state_q == RUN) begin
                s_q[k_q*W +: W] <= sum_word;
                carry_q         <= c_word;
                k_q             <= last ? '0 : k_q + KW'(1);
                if (last) c_q <= c_word;
            end
        end
    end

    assign bus.busy_o = (state_q != IDLE);
    assign bus.done_o = (state_q == DONE);
    assign bus.S_o    = s_q;
    assign bus.C_o    = c_q;

endmodule

// File: tb/tb_cla_multiword_ctrl.sv
// Directed self-checking bench for cla_multiword_ctrl (W=16, WORDS=4).
module tb_cla_multiword_ctrl;

    localparam int unsigned W     = 16;
    localparam int unsigned WORDS = 4;

    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    cla_multiword_ctrl_if #(.W(W), .WORDS(WORDS)) bus ();

    cla_multiword_ctrl #(
        .W     (W),
        .WORDS (WORDS)
    ) dut (
        .CLK_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [63:0] a, input logic [63:0] b, input logic p,
                         input logic sub);
        bus.A_i = a;
        bus.B_i = b;
        bus.P_i = p;
`ifdef CLA_SUB_EN
        bus.sub_i = sub;
`else
        if (sub) $display("note: sub requested without CLA_SUB_EN");
`endif
    endtask

    // Issue one operation from IDLE and check latency, result and the single done pulse.
    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic p, input logic sub,
                          input logic [63:0] exp_s, input logic exp_c);
        int n;
        drive(a, b, p, sub);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        drive(64'hDEAD_BEEF_DEAD_BEEF, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
        check({tag, "_busy"}, {63'd0, bus.busy_o}, 64'd1);
        n = 0;
        while (!bus.done_o && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_latency"}, 64'(n), 64'(WORDS));
        check({tag, "_S"}, bus.S_o, exp_s);
        check({tag, "_C"}, {63'd0, bus.C_o}, {63'd0, exp_c});
        tick();
        check({tag, "_done_1cyc"}, {63'd0, bus.done_o}, 64'd0);
    endtask

    initial begin
        int n_done;
        logic [63:0] s_at_done;
        logic        c_at_done;

        rst_n       = 1'b0;
        bus.start_i = 1'b0;
        drive(64'd0, 64'd0, 1'b0, 1'b0);
        #3;
        check("rst_busy", {63'd0, bus.busy_o}, 64'd0);
        check("rst_done", {63'd0, bus.done_o}, 64'd0);
        check("rst_S",    bus.S_o, 64'd0);
        check("rst_C",    {63'd0, bus.C_o}, 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        run_op("wordcarry", 64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0,
               64'h0000_0000_0001_0000, 1'b0);
        run_op("wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1);
        run_op("cin", 64'd0, 64'd0, 1'b1, 1'b0, 64'd1, 1'b0);
        run_op("mixed", 64'h0123_4567_89AB_CDEF, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
               64'h1234_5678_9ABC_DF00, 1'b0);

        // Start pulse during RUN must be ignored.
        drive(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        drive(64'h0000_0000_0000_1234, 64'd1, 1'b1, 1'b0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        n_done    = 0;
        s_at_done = '0;
        c_at_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done_o) begin
                n_done++;
                s_at_done = bus.S_o;
                c_at_done = bus.C_o;
            end
            tick();
        end
        check("busy_start_ndone", 64'(n_done), 64'd1);
        check("busy_start_S", s_at_done, 64'h0000_0000_0001_0000);
        check("busy_start_C", {63'd0, c_at_done}, 64'd0);
        check("busy_start_idle", {63'd0, bus.busy_o}, 64'd0);
        run_op("after_busy", 64'd2, 64'd3, 1'b0, 1'b0, 64'd5, 1'b0);

        // Reset while RUN is processing word 2.
        drive(64'h1111_2222_3333_4444, 64'd1, 1'b0, 1'b0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_S",    bus.S_o, 64'd0);
        check("midrst_C",    {63'd0, bus.C_o}, 64'd0);
        check("midrst_busy", {63'd0, bus.busy_o}, 64'd0);
        check("midrst_done", {63'd0, bus.done_o}, 64'd0);
        tick();
        rst_n  = 1'b1;
        n_done = 0;
        for (int i = 0; i < 8; i++) begin
            if (bus.done_o) n_done++;
            tick();
        end
        check("midrst_nodone", 64'(n_done), 64'd0);
        run_op("post_rst", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0001, 1'b1, 1'b0,
               64'd2, 1'b1);

`ifdef CLA_SUB_EN
        run_op("sub_neg", 64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0);
        run_op("sub_pos", 64'd7, 64'd5, 1'b0, 1'b1, 64'd2, 1'b1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
